delay_line_mc: RTL and testbench

Multi-channel, runtime-programmable successor to the single-channel pulse delay line. It timestamps rising edges on CHANNELS asynchronous inputs against one shared free-running counter and queues them in a single timestamp FIFO. It then regenerates a modulated burst on each originating channel exactly `delay_cfg` cycles later. It sits between the receive front-end comparators and the transmit drivers.

---
 rtl/delay_line_mc.sv | 176 +++++++++++++++++
 tb/tb_delay_line_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_mc.sv
// Multi-channel programmable pulse delay line: timestamps rising edges against a shared counter,
// queues them in one FIFO, and replays a modulated burst per channel delay_active cycles later.
// Optional build macro: DELAY_LINE_MC_DROP_COUNT_EN enables the saturating dropped-event counter.
module delay_line_mc #(
    parameter int CHANNELS         = 4,
    parameter int FIFO_DEPTH       = 1024,
    parameter int CTR_WIDTH        = 18,
    parameter int TIMEOUT_CYCLES   = 121,
    parameter int HALF_PERIOD_CLKS = 3,
    parameter int PULSE_CYCLES     = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [CHANNELS-1:0]  i_in,
    input  logic [CTR_WIDTH-1:0] i_delay_cfg,
    input  logic                 i_delay_load,
    output logic [CHANNELS-1:0]  o_out,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic [15:0]          o_drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CHANNELS + CTR_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(HALF_PERIOD_CLKS + 1);
    localparam int HW = $clog2(2 * PULSE_CYCLES + 1);
    localparam logic [CTR_WIDTH-1:0] MIN_DELAY = CTR_WIDTH'(8);

    logic [CHANNELS-1:0]  r_sync1, r_sync2, r_sync2_d, r_edge, r_trig, r_active;
    logic [TW-1:0]        r_timer [CHANNELS];
    logic [PW-1:0]        r_ph    [CHANNELS];
    logic [HW-1:0]        r_half  [CHANNELS];
    logic [CTR_WIDTH-1:0] r_ctr, r_delay_active, r_delay_pending;
    logic                 r_busy, r_overflow;
    logic [EW-1:0]        r_mem   [FIFO_DEPTH];
    logic [AW:0]          r_wr_ptr, r_rd_ptr;

    logic [CHANNELS-1:0]  w_rise, w_accept;
    logic [CTR_WIDTH-1:0] w_ts, w_cfg_clamped;
    logic [EW-1:0]        w_head;
    logic                 w_empty, w_full, w_pop, w_push, w_drop, w_quiet;

    assign w_rise        = r_sync2 & ~r_sync2_d;
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    // Equality only: the entry fires exactly once when the counter passes its due time.
    assign w_pop         = !w_empty && (w_head[CTR_WIDTH-1:0] == r_ctr);
    assign w_push        = (|r_edge) && (!w_full || w_pop);
    assign w_drop        = (|r_edge) && w_full && !w_pop;
    assign w_ts          = r_ctr + r_delay_active - CTR_WIDTH'(4);
    assign w_cfg_clamped = (i_delay_cfg < MIN_DELAY) ? MIN_DELAY : i_delay_cfg;
    assign w_quiet       = w_empty && !(|r_edge) && !(|w_rise) && !(|(r_sync1 & ~r_sync2));
    assign o_busy        = r_busy;
    assign o_overflow    = r_overflow;

    // Edge acceptance gated by each channel's lockout timer.
    always_comb begin
        w_accept = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_accept[c] = w_rise[c] && (r_timer[c] == '0);
        end
    end

    // Synchroniser, edge stage and per-channel lockout timers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync2_d <= '0;
            r_edge    <= '0;
            for (int c = 0; c < CHANNELS; c++) r_timer[c] <= '0;
        end else begin
            r_sync1   <= i_in;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_edge    <= w_accept;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_accept[c])
                    r_timer[c] <= TW'(TIMEOUT_CYCLES - 1);
                else if (r_timer[c] != '0)
                    r_timer[c] <= r_timer[c] - TW'(1);
            end
        end
    end

    // Timestamp counter and delay register; a new delay only takes effect once nothing is in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctr           <= '0;
            r_delay_active  <= MIN_DELAY;
            r_delay_pending <= MIN_DELAY;
            r_busy          <= 1'b0;
        end else begin
            r_ctr <= r_ctr + CTR_WIDTH'(1);
            if (i_delay_load) begin
                r_delay_pending <= w_cfg_clamped;
                r_busy          <= 1'b1;
            end else if (r_busy && w_quiet) begin
                r_delay_active <= r_delay_pending;
                r_busy         <= 1'b0;
            end
        end
    end

    // FIFO pointers and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // FIFO storage: {mask, due timestamp}.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r_edge, w_ts};
    end

    // Trigger register and per-channel burst generators.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_trig   <= '0;
            r_active <= '0;
            o_out    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_ph[c]   <= '0;
                r_half[c] <= '0;
            end
        end else begin
            r_trig <= w_pop ? w_head[EW-1:CTR_WIDTH] : '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_trig[c]) begin
                    r_active[c] <= 1'b1;
                    r_ph[c]     <= '0;
                    r_half[c]   <= '0;
                    o_out[c]    <= 1'b1;
                end else if (r_active[c]) begin
                    if (r_ph[c] == PW'(HALF_PERIOD_CLKS - 1)) begin
                        r_ph[c] <= '0;
                        if (r_half[c] == HW'(2 * PULSE_CYCLES - 1)) begin
                            r_active[c] <= 1'b0;
                            o_out[c]    <= 1'b0;
                        end else begin
                            r_half[c] <= r_half[c] + HW'(1);
                            o_out[c]  <= ~o_out[c];
                        end
                    end else begin
                        r_ph[c] <= r_ph[c] + PW'(1);
                    end
                end
            end
        end
    end

`ifdef DELAY_LINE_MC_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    // Saturating count of entries lost to a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_drop_count <= 16'h0000;
        else if (w_drop && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'h0001;
    end

    assign o_drop_count = r_drop_count;
`else
    assign o_drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_delay_line_mc.sv
// Self-checking bench for delay_line_mc: an event-level model (due times, FIFO occupancy,
// burst shape) predicts outputs every cycle; scenario tasks add targeted timing checks.
module tb_delay_line_mc;
    localparam int CH = 4, DEPTH = 4, CW = 11, TO = 121, HP = 3, PC = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] i_in = '0;
    logic [CW-1:0] delay_cfg = '0;
    logic          delay_load = 1'b0;
    logic [CH-1:0] o_out;
    logic          o_busy, o_overflow;
    logic [15:0]   o_drop_count;

    delay_line_mc #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .CTR_WIDTH(CW), .TIMEOUT_CYCLES(TO),
                    .HALF_PERIOD_CLKS(HP), .PULSE_CYCLES(PC)) dut (
        .i_clk(clk), .i_reset(reset), .i_in(i_in), .i_delay_cfg(delay_cfg),
        .i_delay_load(delay_load), .o_out(o_out), .o_busy(o_busy),
        .o_overflow(o_overflow), .o_drop_count(o_drop_count));

    always #5 clk = ~clk;

    typedef struct { logic [CH-1:0] mask; int t; } trig_t;
    trig_t         trig_q[$];
    int            pop_q[$];
    int            drop_q[$];
    int            checks = 0, errors = 0;
    int            cyc = 0, rst_cyc = 0, md = 8, ovf_time = -1;
    int            last_acc[CH];
    logic [CH-1:0] prev_s = '0;
    bit            mon_en = 1'b0;

    // Event-level model: sample inputs each posedge, apply lockout, decide FIFO acceptance.
    always @(posedge clk) begin
        logic [CH-1:0] m;
        int occ;
        cyc++;
        if (reset) begin
            trig_q.delete(); pop_q.delete(); drop_q.delete();
            ovf_time = -1; prev_s = '0; md = 8; rst_cyc = cyc;
            for (int c = 0; c < CH; c++) last_acc[c] = -100000;
        end else begin
            m = '0;
            for (int c = 0; c < CH; c++)
                if (i_in[c] && !prev_s[c] && (cyc - last_acc[c] >= TO)) begin
                    m[c] = 1'b1; last_acc[c] = cyc;
                end
            prev_s = i_in;
            if (m != '0) begin
                occ = 0;
                foreach (pop_q[i]) if (pop_q[i] > cyc + 3) occ++;
                if (occ >= DEPTH) begin
                    drop_q.push_back(cyc + 3);
                    if (ovf_time < 0) ovf_time = cyc + 3;
                end else begin
                    pop_q.push_back(cyc + md - 1);
                    trig_q.push_back('{m, cyc + md});
                end
            end
        end
    end

    // Continuous comparison of outputs against the model.
    always @(negedge clk) begin
        logic [CH-1:0] e;
        logic          eo;
        int            best, d, nd;
        if (mon_en) begin
            for (int c = 0; c < CH; c++) begin
                best = -1;
                foreach (trig_q[i])
                    if (trig_q[i].mask[c] && trig_q[i].t <= cyc && trig_q[i].t > best) best = trig_q[i].t;
                d = cyc - best;
                e[c] = (best >= 0) && (d < 2 * HP * PC) && ((d / HP) % 2 == 0);
            end
            checks++;
            if (o_out !== e) begin
                errors++; $display("FAIL out cyc=%0d got=%b exp=%b", cyc, o_out, e);
            end
            eo = (ovf_time >= 0) && (ovf_time <= cyc);
            checks++;
            if (o_overflow !== eo) begin
                errors++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, o_overflow, eo);
            end
            nd = 0;
`ifdef DELAY_LINE_MC_DROP_COUNT_EN
            foreach (drop_q[i]) if (drop_q[i] <= cyc && nd < 65535) nd++;
`endif
            checks++;
            if (o_drop_count !== 16'(nd)) begin
                errors++; $display("FAIL drop_count cyc=%0d got=%0d exp=%0d", cyc, o_drop_count, nd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        i_in = '0; reset = 1'b1; tick(1); reset = 1'b0;
    endtask

    task automatic load_delay(input int v);
        int n = 0;
        delay_cfg = CW'(v); delay_load = 1'b1; tick(1); delay_load = 1'b0;
        while (o_busy === 1'b1 && n < 2000) begin tick(1); n++; end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL load_timeout got=%b exp=0", o_busy); end
        md = (v < 8) ? 8 : v;
    endtask

    task automatic pulse(input logic [CH-1:0] m, input int w);
        i_in = m; tick(w); i_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(1);
        checks++;
        if ({o_out, o_busy, o_overflow, o_drop_count} !== '0) begin
            errors++; $display("FAIL reset_state got=%b/%b/%b/%0d exp=0", o_out, o_busy, o_overflow, o_drop_count);
        end
        reset = 1'b0; mon_en = 1'b1;
    endtask

    task automatic test_single();
        int k, rises = 0, highs = 1, other = 0;
        load_delay(3);
        load_delay(100);
        k = cyc + 1; pulse(4'b0001, 4);
        tick(k + 99 - cyc);
        checks++;
        if (o_out[0] !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", o_out[0]); end
        tick(1);
        checks++;
        if (o_out[0] !== 1'b1) begin errors++; $display("FAIL single_rise got=%b exp=1", o_out[0]); end
        rises = 1;
        for (int i = 0; i < 100; i++) begin
            logic p;
            p = o_out[0]; tick(1);
            if (o_out[0] && !p) rises++;
            if (o_out[0]) highs++;
            if (o_out[3:1] != 3'b000) other++;
        end
        checks++;
        if (rises != PC || highs != PC * HP || other != 0) begin
            errors++; $display("FAIL single_burst rises=%0d highs=%0d other=%0d exp=%0d/%0d/0", rises, highs, other, PC, PC * HP);
        end
    endtask

    task automatic test_simultaneous();
        int diff = 0, r0 = 0, r13 = 0;
        pulse(4'b0101, 3);
        for (int i = 0; i < 200; i++) begin
            logic [CH-1:0] p;
            p = o_out; tick(1);
            if (o_out[0] !== o_out[2]) diff++;
            if (o_out[0] && !p[0]) r0++;
            if ((o_out[1] && !p[1]) || (o_out[3] && !p[3])) r13++;
        end
        checks++;
        if (diff != 0 || r0 != PC || r13 != 0) begin
            errors++; $display("FAIL simultaneous diff=%0d rises0=%0d rises13=%0d exp=0/%0d/0", diff, r0, r13, PC);
        end
    endtask

    task automatic test_lockout();
        int r1 = 0;
        fork
            begin
                pulse(4'b0010, 3); tick(47); pulse(4'b0010, 3); tick(77); pulse(4'b0010, 3);
            end
            for (int i = 0; i < 360; i++) begin
                logic p;
                p = o_out[1]; tick(1);
                if (o_out[1] && !p) r1++;
            end
        join
        checks++;
        if (r1 != 2 * PC) begin errors++; $display("FAIL lockout rises=%0d exp=%0d", r1, 2 * PC); end
    endtask

    task automatic test_overflow();
        int r[CH];
        load_delay(1000);
        for (int c = 0; c < CH; c++) r[c] = 0;
        fork
            begin
                pulse(4'b0001, 2); tick(8); pulse(4'b0010, 2); tick(8);
                pulse(4'b0100, 2); tick(8); pulse(4'b1000, 2); tick(168); pulse(4'b0001, 2);
            end
            for (int i = 0; i < 1150; i++) begin
                logic [CH-1:0] p;
                p = o_out; tick(1);
                for (int c = 0; c < CH; c++) if (o_out[c] && !p[c]) r[c]++;
            end
        join
        checks++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", o_overflow); end
        checks++;
`ifdef DELAY_LINE_MC_DROP_COUNT_EN
        if (o_drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop got=%0d exp=1", o_drop_count); end
`else
        if (o_drop_count !== 16'd0) begin errors++; $display("FAIL ovf_drop got=%0d exp=0", o_drop_count); end
`endif
        checks++;
        if (r[0] != PC || r[1] != PC || r[2] != PC || r[3] != PC) begin
            errors++; $display("FAIL ovf_bursts got=%0d/%0d/%0d/%0d exp=%0d each", r[0], r[1], r[2], r[3], PC);
        end
    endtask

    task automatic test_delay_change();
        int k1, k2, p, bad = 0;
        do_reset();
        load_delay(300);
        pulse(4'b0001, 3); tick(17);
        k1 = cyc + 1; pulse(4'b0010, 3); tick(20);
        delay_cfg = CW'(200); delay_load = 1'b1; tick(1); delay_load = 1'b0;
        p = k1 + 299;
        while (cyc <= p) begin
            if (o_busy !== 1'b1) bad++;
            tick(1);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_hold bad=%0d exp=0", bad); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_clear got=%b exp=0", o_busy); end
        md = 200;
        tick(5);
        k2 = cyc + 1; pulse(4'b0100, 3);
        tick(k2 + 199 - cyc);
        checks++;
        if (o_out[2] !== 1'b0) begin errors++; $display("FAIL newdly_early got=%b exp=0", o_out[2]); end
        tick(1);
        checks++;
        if (o_out[2] !== 1'b1) begin errors++; $display("FAIL newdly_rise got=%b exp=1", o_out[2]); end
        tick(100);
    endtask

    task automatic test_wrap_reset();
        int k;
        do_reset();
        load_delay(100);
        tick((1990 - (cyc - rst_cyc)) % (1 << CW));
        k = cyc + 1; pulse(4'b1000, 3);
        tick(k + 99 - cyc);
        checks++;
        if (o_out[3] !== 1'b0) begin errors++; $display("FAIL wrap_early got=%b exp=0", o_out[3]); end
        tick(1);
        checks++;
        if (o_out[3] !== 1'b1) begin errors++; $display("FAIL wrap_rise got=%b exp=1", o_out[3]); end
        tick(9); pulse(4'b0001, 3);
        tick(k + 120 - cyc);
        do_reset();
        checks++;
        if (o_out !== '0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL midreset out=%b busy=%b exp=0/0", o_out, o_busy);
        end
        delay_cfg = CW'(50); delay_load = 1'b1; tick(1); delay_load = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL postreset_busy got=%b exp=1", o_busy); end
        tick(1);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL postreset_empty got=%b exp=0", o_busy); end
        md = 50;
        tick(300);
    endtask

    task automatic test_random();
        do_reset();
        load_delay($urandom_range(8, 600));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) i_in = i_in ^ CH'($urandom_range(1, 15));
            tick(1);
        end
        i_in = '0;
        tick(800);
        checks++;
        if (o_out !== '0) begin errors++; $display("FAIL random_idle got=%b exp=0", o_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_lockout();
        test_overflow();
        test_delay_change();
        test_wrap_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
